surf_result_checker: RTL and testbench
======================================

Name: surf_result_checker

Overview:
- Synthesizable, parametrised successor to the SURF determinant self-check bench.
- Sweeps a DUT result SRAM and a golden (SW) result SRAM in lock-step, compares word by word, and reports pass/fail, mismatch count and first failing address.
- Sits after CalcDeterminant on the result-memory side. Allows on-chip/emulator regression with no simulator $display loop.

Parameters:
- A_WIDTH, 17, address width of both result memories.
- D_WIDTH, 16, data width of both memories.
- RD_LAT, 1, read latency in cycles from En/Addr to valid data (1..4).
- CNT_WIDTH, 17, width of compare and error counters.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset; asynchronous, active-low.
- Go  in  1  one-cycle start pulse; sampled only in IDLE.
- Len  in  A_WIDTH  number of words to check (e.g. 75516); latched on Go.
- Skip_Zero  in  1  1 = ignore addresses where DUT word == 0; latched on Go.
- Dut_Addr  out  A_WIDTH  DUT result memory address.
- Dut_En  out  1  DUT memory enable.
- Dut_RW  out  1  held 1 (read); checker never writes.
- Dut_Data  in  D_WIDTH  DUT memory read data.
- Ref_Addr  out  A_WIDTH  golden memory address; always equal to Dut_Addr.
- Ref_En  out  1  golden memory enable; always equal to Dut_En.
- Ref_Data  in  D_WIDTH  golden memory read data.
- Done  out  1  high for exactly one cycle when the sweep completes.
- Pass  out  1  valid from Done onward: 1 iff Err_Count == 0.
- Err_Count  out  CNT_WIDTH  mismatches found; saturates at all-ones.
- Cmp_Count  out  CNT_WIDTH  words actually compared (skipped words excluded).
- First_Err_Addr  out  A_WIDTH  address of first mismatch; 0 if none.
- Busy  out  1  high in ISSUE and DRAIN.

Behaviour:
- Reset: all outputs 0, except Dut_RW = 1. FSM goes to IDLE; issue pipeline flushed. Reset mid-sweep aborts with no Done.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - Go=1 with Len>0: latch Len and Skip_Zero, clear counters, First_Err_Addr and Pass, go to ISSUE.
  - Go=1 with Len=0: go directly to DONE (Pass=1, counts 0).
- ISSUE:
  - One read per cycle: En=1, Addr = 0, 1, … Len-1.
  - After address Len-1 is issued, go to DRAIN.
- Pipeline: an RD_LAT-deep shift register carries {valid, addr}. Data is compared when the valid bit emerges, which is RD_LAT cycles after issue.
- DRAIN: En=0. Wait until the pipeline is empty, then go to DONE.
- DONE: Done=1 for one cycle, Pass = (Err_Count==0), then IDLE. Results hold until the next Go.
- Compare stage, per valid beat:
  - If Skip_Zero and Dut_Data==0: no count change.
  - Otherwise Cmp_Count += 1. If Dut_Data != Ref_Data, Err_Count += 1 (saturating).
  - On the first mismatch only, latch First_Err_Addr.
- Go while Busy or in DONE is ignored.
- Address counter never wraps: the sweep stops at Len-1. Len = 2**A_WIDTH-1 is the maximum length.
- Latency: Done asserts Len + RD_LAT + 1 cycles after the Go edge.
- Counters never exceed Len; CNT_WIDTH >= A_WIDTH is enforced by a generate-time check.

Optional Feature:
- Macro: SURF_CHECK_TOLERANCE_EN
- Defined:
  - Adds input Tol [D_WIDTH-1:0], latched on Go.
  - A word is a mismatch only if |Dut_Data - Ref_Data| > Tol, computed unsigned at D_WIDTH+1 bits.
  - Adds output Max_Diff [D_WIDTH-1:0]: the largest absolute difference seen over compared words, reset to 0.
- Undefined: exact equality only; no Tol port, no Max_Diff port.

Decomposition:
- Package surf_pkg holds:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2, DONE=2'd3).
  - Default A_WIDTH / D_WIDTH / DetMSize (75516) constants shared with CalcDeterminant.
- One sub-module: surf_check_pipe, the RD_LAT-deep {valid, addr} delay line plus compare/diff logic.
- The top level keeps the FSM, address generator and counters.

Test Plan:
- Identical memories, Len=16, Skip_Zero=0, RD_LAT=1 -> Done at cycle 18 after Go; Pass=1, Err=0, Cmp=16.
- Mismatches at addresses 5 and 9 (0x1234 vs 0x1235), Len=16 -> Err=2, First_Err_Addr=5, Pass=0.
- Skip_Zero=1, DUT words 0 at 8 of 16 addresses, golden differs only at those zero addresses -> Err=0, Cmp=8, Pass=1.
- Len=0 Go -> Done next cycle, Pass=1, Cmp=0. Go pulsed again mid-sweep (Len=16) -> ignored; single Done.
- Rst driven low at address 7 of a Len=16 sweep -> all outputs 0 immediately and no Done. A fresh Go after release completes normally.
- With SURF_CHECK_TOLERANCE_EN and Tol=2: diffs of 1 and 3 -> Err=1, Max_Diff=3. RD_LAT=3 -> Done at Len+4 cycles.

Source files
------------

// File: rtl/surf_pkg.sv
// Shared constants and FSM encoding for the SURF result checker and CalcDeterminant.
package surf_pkg;
   localparam int SURF_A_WIDTH = 17;
   localparam int SURF_D_WIDTH = 16;
   localparam int DetMSize     = 75516;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } surf_state_e;
endpackage

// File: rtl/surf_check_pipe.sv
// RD_LAT-deep {valid, addr} delay line aligned with memory read data, plus the per-beat compare.
// SURF_CHECK_TOLERANCE_EN switches the compare from exact equality to |dut - ref| > tol.
module surf_check_pipe
   import surf_pkg::*;
#(
   parameter int A_WIDTH = SURF_A_WIDTH,
   parameter int D_WIDTH = SURF_D_WIDTH,
   parameter int RD_LAT  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               issue_valid,
   input  logic [A_WIDTH-1:0] issue_addr,
   input  logic [D_WIDTH-1:0] dut_data,
   input  logic [D_WIDTH-1:0] ref_data,
   input  logic               skip_zero,
`ifdef SURF_CHECK_TOLERANCE_EN
   input  logic [D_WIDTH-1:0] tol,
   output logic [D_WIDTH-1:0] beat_diff,
`endif
   output logic               beat_valid,
   output logic               beat_mismatch,
   output logic [A_WIDTH-1:0] beat_addr,
   output logic               pipe_empty
);

   logic [RD_LAT-1:0]  vld_q, vld_d;
   logic [A_WIDTH-1:0] addr_q [RD_LAT];
   logic [A_WIDTH-1:0] addr_d [RD_LAT];
   logic               skip_beat;

   always_comb begin
      vld_d     = vld_q;
      addr_d    = addr_q;
      vld_d[0]  = issue_valid;
      addr_d[0] = issue_addr;
      for (int i = 1; i < RD_LAT; i++) begin
         vld_d[i]  = vld_q[i-1];
         addr_d[i] = addr_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
      end else begin
         vld_q  <= vld_d;
         addr_q <= addr_d;
      end
   end

   // The last stage lines up with read data issued RD_LAT cycles earlier.
   assign beat_addr  = addr_q[RD_LAT-1];
   assign skip_beat  = skip_zero && (dut_data == '0);
   assign beat_valid = vld_q[RD_LAT-1] && !skip_beat;
   assign pipe_empty = (vld_q == '0);

`ifdef SURF_CHECK_TOLERANCE_EN
   logic [D_WIDTH:0] diff_w;

   always_comb begin
      if (dut_data >= ref_data) diff_w = {1'b0, dut_data} - {1'b0, ref_data};
      else                      diff_w = {1'b0, ref_data} - {1'b0, dut_data};
   end

   assign beat_mismatch = (diff_w > {1'b0, tol});
   assign beat_diff     = diff_w[D_WIDTH-1:0];
`else
   assign beat_mismatch = (dut_data != ref_data);
`endif

endmodule

// File: rtl/surf_result_checker.sv
// Lock-step sweep of DUT and golden result memories with pass/fail, counts and first error address.
// Optional SURF_CHECK_TOLERANCE_EN adds the Tol input and Max_Diff output.
module surf_result_checker
   import surf_pkg::*;
#(
   parameter int A_WIDTH   = SURF_A_WIDTH,
   parameter int D_WIDTH   = SURF_D_WIDTH,
   parameter int RD_LAT    = 1,
   parameter int CNT_WIDTH = 17
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Go,
   input  logic [A_WIDTH-1:0]   Len,
   input  logic                 Skip_Zero,
   output logic [A_WIDTH-1:0]   Dut_Addr,
   output logic                 Dut_En,
   output logic                 Dut_RW,
   input  logic [D_WIDTH-1:0]   Dut_Data,
   output logic [A_WIDTH-1:0]   Ref_Addr,
   output logic                 Ref_En,
   input  logic [D_WIDTH-1:0]   Ref_Data,
`ifdef SURF_CHECK_TOLERANCE_EN
   input  logic [D_WIDTH-1:0]   Tol,
   output logic [D_WIDTH-1:0]   Max_Diff,
`endif
   output logic                 Done,
   output logic                 Pass,
   output logic [CNT_WIDTH-1:0] Err_Count,
   output logic [CNT_WIDTH-1:0] Cmp_Count,
   output logic [A_WIDTH-1:0]   First_Err_Addr,
   output logic                 Busy,
   output logic [1:0]           Dbg_State
);

   if (CNT_WIDTH < A_WIDTH) begin : g_cnt_width_check
      $error("CNT_WIDTH must be >= A_WIDTH");
   end
   if (RD_LAT < 1 || RD_LAT > 4) begin : g_rd_lat_check
      $error("RD_LAT must be in 1..4");
   end

   surf_state_e          state_q, state_d;
   logic [A_WIDTH-1:0]   len_q, len_d, addr_q, addr_d, first_q, first_d;
   logic                 skip_q, skip_d, pass_q, pass_d;
   logic [CNT_WIDTH-1:0] err_q, err_d, cmp_q, cmp_d;
   logic                 last_issue, accept_go;
   logic                 beat_valid, beat_mismatch, pipe_empty;
   logic [A_WIDTH-1:0]   beat_addr;

   assign last_issue = (addr_q == len_q - A_WIDTH'(1));
   assign accept_go  = (state_q == ST_IDLE) && Go;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (Go) state_d = (Len == '0) ? ST_DONE : ST_ISSUE;
         ST_ISSUE: if (last_issue) state_d = ST_DRAIN;
         ST_DRAIN: if (pipe_empty) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Read request: Dut_En high means a read of Dut_Addr is issued that cycle; there is no
   // back-pressure, and the data is taken as valid exactly RD_LAT cycles later.
   always_comb begin
      Dut_En   = (state_q == ST_ISSUE);
      Dut_Addr = Dut_En ? addr_q : '0;
      Busy     = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
      Done     = (state_q == ST_DONE);
   end

   assign Ref_En         = Dut_En;
   assign Ref_Addr       = Dut_Addr;
   assign Dut_RW         = 1'b1;
   assign Pass           = pass_q;
   assign Err_Count      = err_q;
   assign Cmp_Count      = cmp_q;
   assign First_Err_Addr = first_q;
   assign Dbg_State      = state_q;

   always_comb begin
      len_d   = len_q;
      skip_d  = skip_q;
      addr_d  = addr_q;
      err_d   = err_q;
      cmp_d   = cmp_q;
      first_d = first_q;
      pass_d  = pass_q;
      if (accept_go) begin
         len_d   = Len;
         skip_d  = Skip_Zero;
         addr_d  = '0;
         err_d   = '0;
         cmp_d   = '0;
         first_d = '0;
         pass_d  = (Len == '0);
      end
      if (state_q == ST_ISSUE && !last_issue) addr_d = addr_q + A_WIDTH'(1);
      if (beat_valid) begin
         cmp_d = cmp_q + CNT_WIDTH'(1);
         if (beat_mismatch) begin
            if (err_q != '1) err_d = err_q + CNT_WIDTH'(1);
            if (err_q == '0) first_d = beat_addr;
         end
      end
      // Counters are final once the pipe has drained.
      if (state_q == ST_DRAIN && pipe_empty) pass_d = (err_q == '0);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         len_q   <= '0;
         skip_q  <= 1'b0;
         addr_q  <= '0;
         err_q   <= '0;
         cmp_q   <= '0;
         first_q <= '0;
         pass_q  <= 1'b0;
      end else begin
         len_q   <= len_d;
         skip_q  <= skip_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         cmp_q   <= cmp_d;
         first_q <= first_d;
         pass_q  <= pass_d;
      end
   end

`ifdef SURF_CHECK_TOLERANCE_EN
   logic [D_WIDTH-1:0] tol_q, tol_d, max_q, max_d, beat_diff;

   always_comb begin
      tol_d = tol_q;
      max_d = max_q;
      if (accept_go) begin
         tol_d = Tol;
         max_d = '0;
      end
      if (beat_valid && beat_diff > max_q) max_d = beat_diff;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         tol_q <= '0;
         max_q <= '0;
      end else begin
         tol_q <= tol_d;
         max_q <= max_d;
      end
   end

   assign Max_Diff = max_q;
`endif

   surf_check_pipe #(
      .A_WIDTH (A_WIDTH),
      .D_WIDTH (D_WIDTH),
      .RD_LAT  (RD_LAT)
   ) u_pipe (
      .clk           (Clk),
      .rst_n         (Rst),
      .issue_valid   (Dut_En),
      .issue_addr    (addr_q),
      .dut_data      (Dut_Data),
      .ref_data      (Ref_Data),
      .skip_zero     (skip_q),
`ifdef SURF_CHECK_TOLERANCE_EN
      .tol           (tol_q),
      .beat_diff     (beat_diff),
`endif
      .beat_valid    (beat_valid),
      .beat_mismatch (beat_mismatch),
      .beat_addr     (beat_addr),
      .pipe_empty    (pipe_empty)
   );

endmodule

// File: tb/tb_surf_result_checker.sv
// Directed table-driven bench for surf_result_checker at RD_LAT=1 and RD_LAT=3 side by side.
// Builds with or without SURF_CHECK_TOLERANCE_EN.
module tb_surf_result_checker;
   localparam int AW = 17;
   localparam int DW = 16;
   localparam int CW = 17;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          go;
   logic [AW-1:0] len;
   logic          skip;
`ifdef SURF_CHECK_TOLERANCE_EN
   logic [DW-1:0] tol;
   logic [DW-1:0] max_1, max_3;
`endif

   logic [AW-1:0] addr_1, raddr_1, first_1, addr_3, raddr_3, first_3;
   logic          en_1, ren_1, rw_1, done_1, pass_1, busy_1;
   logic          en_3, ren_3, rw_3, done_3, pass_3, busy_3;
   logic [DW-1:0] dd_1, rd_1, dd_3, rd_3;
   logic [CW-1:0] err_1, cmp_1, err_3, cmp_3;
   logic [1:0]    st_1, st_3;

   logic [DW-1:0] dut_mem [32];
   logic [DW-1:0] ref_mem [32];
   logic [DW-1:0] d3p [3];
   logic [DW-1:0] r3p [3];

   surf_result_checker #(.A_WIDTH(AW), .D_WIDTH(DW), .RD_LAT(1), .CNT_WIDTH(CW)) u_dut1 (
      .Clk(clk), .Rst(rst_n), .Go(go), .Len(len), .Skip_Zero(skip),
      .Dut_Addr(addr_1), .Dut_En(en_1), .Dut_RW(rw_1), .Dut_Data(dd_1),
      .Ref_Addr(raddr_1), .Ref_En(ren_1), .Ref_Data(rd_1),
`ifdef SURF_CHECK_TOLERANCE_EN
      .Tol(tol), .Max_Diff(max_1),
`endif
      .Done(done_1), .Pass(pass_1), .Err_Count(err_1), .Cmp_Count(cmp_1),
      .First_Err_Addr(first_1), .Busy(busy_1), .Dbg_State(st_1)
   );

   surf_result_checker #(.A_WIDTH(AW), .D_WIDTH(DW), .RD_LAT(3), .CNT_WIDTH(CW)) u_dut3 (
      .Clk(clk), .Rst(rst_n), .Go(go), .Len(len), .Skip_Zero(skip),
      .Dut_Addr(addr_3), .Dut_En(en_3), .Dut_RW(rw_3), .Dut_Data(dd_3),
      .Ref_Addr(raddr_3), .Ref_En(ren_3), .Ref_Data(rd_3),
`ifdef SURF_CHECK_TOLERANCE_EN
      .Tol(tol), .Max_Diff(max_3),
`endif
      .Done(done_3), .Pass(pass_3), .Err_Count(err_3), .Cmp_Count(cmp_3),
      .First_Err_Addr(first_3), .Busy(busy_3), .Dbg_State(st_3)
   );

   // Memory models: one-cycle SRAM for dut1, three-cycle read pipeline for dut3.
   always @(posedge clk) begin
      if (en_1)  dd_1 <= dut_mem[addr_1[4:0]];
      if (ren_1) rd_1 <= ref_mem[raddr_1[4:0]];
      if (en_3)  d3p[0] <= dut_mem[addr_3[4:0]];
      if (ren_3) r3p[0] <= ref_mem[raddr_3[4:0]];
      d3p[1] <= d3p[0];
      d3p[2] <= d3p[1];
      r3p[1] <= r3p[0];
      r3p[2] <= r3p[1];
   end
   assign dd_3 = d3p[2];
   assign rd_3 = r3p[2];

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int len; int skip; int pat; int mid_go; int tol;
      int exp_err; int exp_cmp; int exp_first; int exp_pass;
      int exp_lat1; int exp_lat3; int exp_max;
   } vec_t;

   vec_t vecs [10];

   task automatic load_pat(input int p);
      for (int i = 0; i < 32; i++) begin
         dut_mem[i] = DW'(16'h1000 + i);
         ref_mem[i] = DW'(16'h1000 + i);
         case (p)
            1: if (i == 5 || i == 9) begin
                  dut_mem[i] = 16'h1234;
                  ref_mem[i] = 16'h1235;
               end
            2: if (i % 2 == 0) begin
                  dut_mem[i] = 16'h0000;
                  ref_mem[i] = 16'h00FF;
               end
            3: begin
                  dut_mem[i] = DW'(16'h3000 + i);
                  ref_mem[i] = DW'(16'h3000 + i);
                  if (i == 2) ref_mem[i] = 16'h3003;
                  if (i == 4) ref_mem[i] = 16'h3001;
               end
            default: ;
         endcase
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int n, lat1, lat3, nd1, nd3;
      string tag;
      tag = $sformatf("v%0d", idx);
      load_pat(v.pat);
      @(negedge clk);
      go   = 1'b1;
      len  = AW'(v.len);
      skip = v.skip[0];
`ifdef SURF_CHECK_TOLERANCE_EN
      tol  = DW'(v.tol);
`endif
      @(posedge clk);
      @(negedge clk);
      go = 1'b0;
      n = 0; nd1 = 0; nd3 = 0; lat1 = -1; lat3 = -1;
      while (n <= v.exp_lat3 + 3) begin
         if (done_1) begin nd1++; if (lat1 < 0) lat1 = n; end
         if (done_3) begin nd3++; if (lat3 < 0) lat3 = n; end
         if (n == 1) check({tag, " busy_1"}, 64'(busy_1), 64'(v.len != 0));
         go = 1'b0;
         if (v.mid_go == 1 && n == 5) begin go = 1'b1; len = AW'(1); end
         if (v.mid_go == 2 && n == v.exp_lat1) begin go = 1'b1; len = AW'(1); end
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      go = 1'b0;
      check({tag, " lat_1"},   64'(lat1),    64'(v.exp_lat1));
      check({tag, " lat_3"},   64'(lat3),    64'(v.exp_lat3));
      check({tag, " ndone_1"}, 64'(nd1),     64'd1);
      check({tag, " ndone_3"}, 64'(nd3),     64'd1);
      check({tag, " err_1"},   64'(err_1),   64'(v.exp_err));
      check({tag, " cmp_1"},   64'(cmp_1),   64'(v.exp_cmp));
      check({tag, " first_1"}, 64'(first_1), 64'(v.exp_first));
      check({tag, " pass_1"},  64'(pass_1),  64'(v.exp_pass));
      check({tag, " err_3"},   64'(err_3),   64'(v.exp_err));
      check({tag, " cmp_3"},   64'(cmp_3),   64'(v.exp_cmp));
      check({tag, " first_3"}, 64'(first_3), 64'(v.exp_first));
      check({tag, " pass_3"},  64'(pass_3),  64'(v.exp_pass));
      check({tag, " busy_end"}, 64'({busy_1, busy_3}), 64'd0);
`ifdef SURF_CHECK_TOLERANCE_EN
      check({tag, " max_1"},   64'(max_1),   64'(v.exp_max));
      check({tag, " max_3"},   64'(max_3),   64'(v.exp_max));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int found, nd;
      go = 1'b0; len = '0; skip = 1'b0;
`ifdef SURF_CHECK_TOLERANCE_EN
      tol = '0;
`endif
      load_pat(0);

      // len skip pat mid_go tol | err cmp first pass lat1 lat3 max
      vecs[0] = '{16, 0, 0, 0, 0,  0, 16, 0, 1, 18, 20, 0};
      vecs[1] = '{16, 0, 1, 0, 0,  2, 16, 5, 0, 18, 20, 1};
      vecs[2] = '{16, 1, 2, 0, 0,  0,  8, 0, 1, 18, 20, 0};
      vecs[3] = '{16, 0, 2, 0, 0,  8, 16, 0, 0, 18, 20, 255};
      vecs[4] = '{ 1, 0, 1, 0, 0,  0,  1, 0, 1,  3,  5, 0};
      vecs[5] = '{10, 0, 1, 0, 0,  2, 10, 5, 0, 12, 14, 1};
      vecs[6] = '{ 0, 0, 0, 0, 0,  0,  0, 0, 1,  0,  0, 0};
      vecs[7] = '{16, 1, 1, 1, 0,  2, 16, 5, 0, 18, 20, 1};
      vecs[8] = '{16, 0, 0, 2, 0,  0, 16, 0, 1, 18, 20, 0};
`ifdef SURF_CHECK_TOLERANCE_EN
      vecs[9] = '{16, 0, 3, 0, 2,  1, 16, 4, 0, 18, 20, 3};
`else
      vecs[9] = '{16, 0, 3, 0, 2,  2, 16, 2, 0, 18, 20, 3};
`endif

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst done",  64'({done_1, done_3}), 64'd0);
      check("rst pass",  64'({pass_1, pass_3}), 64'd0);
      check("rst err",   64'(err_1 | err_3),    64'd0);
      check("rst cmp",   64'(cmp_1 | cmp_3),    64'd0);
      check("rst first", 64'(first_1 | first_3), 64'd0);
      check("rst busy",  64'({busy_1, busy_3}), 64'd0);
      check("rst en",    64'({en_1, ren_1, en_3, ren_3}), 64'd0);
      check("rst addr",  64'(addr_1 | raddr_1 | addr_3 | raddr_3), 64'd0);
      check("rst rw",    64'({rw_1, rw_3}), 64'd3);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // Reset asserted while address 7 is being read aborts the sweep silently.
      load_pat(1);
      @(negedge clk);
      go = 1'b1; len = AW'(16); skip = 1'b0;
      @(negedge clk);
      go = 1'b0;
      found = 0;
      for (int k = 0; k < 40 && found == 0; k++) begin
         if (en_1 && addr_1 == AW'(7)) found = 1;
         else @(negedge clk);
      end
      check("rstseq reach addr7", 64'(found), 64'd1);
      check("rstseq err before", 64'(err_1), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rstseq done",  64'({done_1, done_3}), 64'd0);
      check("rstseq busy",  64'({busy_1, busy_3}), 64'd0);
      check("rstseq en",    64'({en_1, en_3}),     64'd0);
      check("rstseq addr",  64'(addr_1 | addr_3), 64'd0);
      check("rstseq err",   64'(err_1 | err_3),    64'd0);
      check("rstseq cmp",   64'(cmp_1 | cmp_3),    64'd0);
      check("rstseq first", 64'(first_1),          64'd0);
      check("rstseq rw",    64'({rw_1, rw_3}),     64'd3);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (done_1 || done_3) nd++;
      end
      check("rstseq no done", 64'(nd), 64'd0);
      run_vec(10, vecs[1]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
